// File: rtl/arbitro_memoria.sv
// Round-robin initiator for the shared data memory: two cores, single-word
// read/write transactions, one in flight at a time, registered memory strobes.
module arbitro_memoria #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 512,
  parameter int READ_LAT  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdat0,
  input  logic [DATA_W-1:0] wdat1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdat0,
  output logic [DATA_W-1:0] rdat1,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] indata,
  output logic              lerMem,
  output logic              escMem,
  input  logic [DATA_W-1:0] output_mem
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE, S_ERR} state_t;

  state_t            r_state, w_next;
  logic              r_we, r_id, r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_cnt;

  logic              r_ack0, r_ack1, r_err0, r_err1, r_ler, r_esc;
  logic [DATA_W-1:0] r_rdat0, r_rdat1, r_ind;
  logic [ADDR_W-1:0] r_end;

  logic              w_sel_id, w_t_id, w_t_we;
  logic [ADDR_W-1:0] w_t_addr;
  logic [DATA_W-1:0] w_t_wdat;
  logic              w_ack0, w_ack1, w_err0, w_err1, w_ler, w_esc;
  logic [DATA_W-1:0] w_ind;
  logic [ADDR_W-1:0] w_end;

  // On a tie the core that did not complete last wins.
  assign w_sel_id = (req0 & req1) ? ~r_last : req1;

  always_comb begin
    w_t_id   = r_id;
    w_t_we   = r_we;
    w_t_addr = r_addr;
    w_t_wdat = w_sel_id ? wdat1 : wdat0;
    if (r_state == S_IDLE) begin
      w_t_id   = w_sel_id;
      w_t_we   = w_sel_id ? we1 : we0;
      w_t_addr = w_sel_id ? addr1 : addr0;
    end

    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req0 | req1)
                  w_next = (w_t_addr >= ADDR_W'(MEM_DEPTH)) ? S_ERR : S_ACCESS;
      S_ACCESS: w_next = r_we ? S_DONE : S_WAIT;
      S_WAIT:   if (r_cnt == '0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    // Outputs are computed for the state being entered, then registered.
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    w_err0 = 1'b0;
    w_err1 = 1'b0;
    w_ler  = 1'b0;
    w_esc  = 1'b0;
    w_ind  = '0;
    w_end  = '0;
    case (w_next)
      S_ACCESS: begin
        w_end = w_t_addr;
        w_esc = w_t_we;
        w_ler = ~w_t_we;
        w_ind = w_t_we ? w_t_wdat : '0;
      end
      S_WAIT: begin
        w_end = r_addr;
        w_ler = 1'b1;
      end
      S_DONE: begin
        w_ack0 = ~r_id;
        w_ack1 = r_id;
      end
      S_ERR: begin
        w_ack0 = ~w_t_id;
        w_ack1 = w_t_id;
        w_err0 = ~w_t_id;
        w_err1 = w_t_id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_id    <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      r_ler   <= 1'b0;
      r_esc   <= 1'b0;
      r_ind   <= '0;
      r_end   <= '0;
      r_rdat0 <= '0;
      r_rdat1 <= '0;
    end else begin
      r_state <= w_next;
      r_ack0  <= w_ack0;
      r_ack1  <= w_ack1;
      r_err0  <= w_err0;
      r_err1  <= w_err1;
      r_ler   <= w_ler;
      r_esc   <= w_esc;
      r_ind   <= w_ind;
      r_end   <= w_end;
      if (r_state == S_IDLE) begin
        r_id   <= w_t_id;
        r_we   <= w_t_we;
        r_addr <= w_t_addr;
      end
      if (r_state == S_ACCESS)
        r_cnt <= CW'(READ_LAT - 1);
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
      if (r_state == S_WAIT && r_cnt == '0) begin
        if (r_id) r_rdat1 <= output_mem;
        else      r_rdat0 <= output_mem;
      end
      if (r_state == S_DONE || r_state == S_ERR)
        r_last <= r_id;
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign err0     = r_err0;
  assign err1     = r_err1;
  assign rdat0    = r_rdat0;
  assign rdat1    = r_rdat1;
  assign endereco = r_end;
  assign indata   = r_ind;
  assign lerMem   = r_ler;
  assign escMem   = r_esc;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: directed scenarios plus random single transactions
// against a transaction-level model (memory contents, per-core read data, last grant).
module tb_arbitro_memoria;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdat0, wdat1;
  logic        ack0, ack1, err0, err1, lerMem, escMem;
  logic [31:0] rdat0, rdat1, endereco, indata, output_mem;

  logic        b_req0, b_req1, b_we0, b_we1;
  logic [31:0] b_addr0, b_addr1, b_wdat0, b_wdat1;
  logic        b_ack0, b_ack1, b_err0, b_err1, b_lerMem, b_escMem;
  logic [31:0] b_rdat0, b_rdat1, b_endereco, b_indata, b_output_mem;

  logic        mem_init;
  logic [31:0] mem_bus [0:511];
  logic [31:0] ref_mem [0:511];
  logic [31:0] ref_rdat [0:1];
  int          ref_last;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  arbitro_memoria #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(512), .READ_LAT(1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdat0(rdat0), .rdat1(rdat1), .endereco(endereco), .indata(indata),
    .lerMem(lerMem), .escMem(escMem), .output_mem(output_mem));

  arbitro_memoria #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(512), .READ_LAT(3)) u_lat3 (
    .clock(clock), .reset_n(reset_n),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdat0(b_wdat0), .wdat1(b_wdat1),
    .ack0(b_ack0), .ack1(b_ack1), .err0(b_err0), .err1(b_err1),
    .rdat0(b_rdat0), .rdat1(b_rdat1), .endereco(b_endereco), .indata(b_indata),
    .lerMem(b_lerMem), .escMem(b_escMem), .output_mem(b_output_mem));

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  // Memory behind the main DUT: combinational read, write on the strobe edge.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem_bus[i] <= init_val(i);
    end else if (escMem && endereco < 32'd512) begin
      mem_bus[endereco[8:0]] <= indata;
    end
  end
  assign output_mem   = lerMem ? mem_bus[endereco[8:0]] : 32'h0;
  assign b_output_mem = b_lerMem ? (b_endereco ^ 32'hC0DE_0000) : 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int core, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (core == 0) begin req0 = r; we0 = w; addr0 = a; wdat0 = d; end
    else           begin req1 = r; we1 = w; addr1 = a; wdat1 = d; end
  endtask

  // One complete request/ack handshake on one core, checked against the model.
  task automatic txn(input int core, input logic we, input logic [31:0] a, input logic [31:0] d);
    int          n = 0, n_esc = 0, n_ler = 0;
    logic        seen = 1'b0;
    logic [31:0] e_addr = '0, e_dat = '0;
    logic        exp_err = (a >= 32'd512);
    int          exp_lat = exp_err ? 1 : (we ? 2 : 3);
    logic [31:0] exp_rd  = (!exp_err && !we) ? ref_mem[a[8:0]] : ref_rdat[core];
    drive(core, 1'b1, we, a, d);
    while (!seen && n < 20) begin
      @(posedge clock); #1;
      n++;
      chk("ack_exclusive", 64'(ack0 & ack1), 64'd0);
      if (escMem) begin n_esc++; e_addr = endereco; e_dat = indata; end
      if (lerMem) n_ler++;
      seen = (core == 0) ? ack0 : ack1;
    end
    drive(core, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ack_seen", 64'(seen), 64'd1);
    chk("latency", 64'(n), 64'(exp_lat));
    chk("err", 64'((core == 0) ? err0 : err1), 64'(exp_err));
    chk("rdat", 64'((core == 0) ? rdat0 : rdat1), 64'(exp_rd));
    chk("esc_cycles", 64'(n_esc), 64'((!exp_err && we) ? 1 : 0));
    chk("ler_cycles", 64'(n_ler), 64'((!exp_err && !we) ? 2 : 0));
    if (we && !exp_err) begin
      chk("wr_addr", 64'(e_addr), 64'(a));
      chk("wr_data", 64'(e_dat), 64'(d));
      ref_mem[a[8:0]] = d;
    end
    if (!we && !exp_err) ref_rdat[core] = exp_rd;
    ref_last = core;
    @(posedge clock); #1;
    chk("ack_pulse", 64'({ack0, ack1}), 64'd0);
  endtask

  initial begin
    int rem0, rem1, cnt, cyc, n, nl, first;
    int ord [0:7];
    logic seen;

    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    ref_rdat[0] = '0; ref_rdat[1] = '0; ref_last = 1;
    mem_init = 1'b1;
    reset_n = 1'b0;
    req1 = 0; we1 = 0; addr1 = '0; wdat1 = '0;
    b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
    b_addr0 = '0; b_addr1 = '0; b_wdat0 = '0; b_wdat1 = '0;
    drive(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);

    // Reset held with a pending request: everything stays quiet.
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      mem_init = 1'b0;
      chk("rst_ctl", 64'({ack0, ack1, err0, err1, lerMem, escMem}), 64'd0);
      chk("rst_data", 64'(|{rdat0, rdat1, endereco, indata}), 64'd0);
      chk("rst_lat3", 64'(|{b_ack0, b_ack1, b_err0, b_err1, b_lerMem, b_escMem,
                             b_rdat0, b_rdat1, b_endereco, b_indata}), 64'd0);
    end
    reset_n = 1'b1;
    txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'd5, 32'h0);

    // Range error on core 1 leaves its read data alone.
    txn(1, 1'b0, 32'd7, 32'h0);
    txn(1, 1'b0, 32'd512, 32'h0);
    txn(0, 1'b1, 32'd511, 32'h1234_5678);
    txn(0, 1'b0, 32'd511, 32'h0);

    // Contention: both cores keep four writes each in flight.
    rem0 = 4; rem1 = 4; cnt = 0; cyc = 0;
    for (int i = 0; i < 8; i++) ord[i] = -1;
    first = (ref_last == 0) ? 1 : 0;
    drive(0, 1'b1, 1'b1, 32'd20, 32'h1000_0000);
    drive(1, 1'b1, 1'b1, 32'd40, 32'h2000_0000);
    while ((rem0 > 0 || rem1 > 0) && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      chk("cont_ack_exclusive", 64'(ack0 & ack1), 64'd0);
      if (ack0) begin
        ref_mem[addr0[8:0]] = wdat0;
        if (cnt < 8) ord[cnt] = 0;
        cnt++; rem0--;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end else if (!req0 && rem0 > 0) begin
        drive(0, 1'b1, 1'b1, 32'(24 - rem0), 32'h1000_0000 + 32'(rem0));
      end
      if (ack1) begin
        ref_mem[addr1[8:0]] = wdat1;
        if (cnt < 8) ord[cnt] = 1;
        cnt++; rem1--;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end else if (!req1 && rem1 > 0) begin
        drive(1, 1'b1, 1'b1, 32'(44 - rem1), 32'h2000_0000 + 32'(rem1));
      end
    end
    chk("cont_count", 64'(cnt), 64'd8);
    for (int i = 0; i < 8; i++) chk("cont_order", 64'(ord[i]), 64'((first + i) % 2));
    ref_last = ord[7];
    @(posedge clock); #1;
    txn(1, 1'b0, 32'd23, 32'h0);
    txn(0, 1'b0, 32'd43, 32'h0);

    // Reset in the middle of a read: abandoned, never acked.
    drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
    @(posedge clock); #1;
    chk("mid_access_ler", 64'(lerMem), 64'd1);
    @(posedge clock); #1;
    chk("mid_wait_ler", 64'(lerMem), 64'd1);
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    chk("mid_rst_ler", 64'({lerMem, escMem}), 64'd0);
    chk("mid_rst_ack", 64'({ack0, ack1}), 64'd0);
    reset_n = 1'b1;
    ref_rdat[0] = '0; ref_rdat[1] = '0; ref_last = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk("mid_no_ack", 64'({ack0, ack1}), 64'd0);
    end
    txn(0, 1'b0, 32'd5, 32'h0);

    // Longer read latency on the second instance.
    b_req0 = 1'b1; b_addr0 = 32'd9;
    n = 0; nl = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clock); #1;
      n++;
      if (b_lerMem) nl++;
      seen = b_ack0;
    end
    b_req0 = 1'b0;
    chk("lat3_ack_seen", 64'(seen), 64'd1);
    chk("lat3_latency", 64'(n), 64'd5);
    chk("lat3_ler_cycles", 64'(nl), 64'd4);
    chk("lat3_rdat", 64'(b_rdat0), 64'(32'd9 ^ 32'hC0DE_0000));
    chk("lat3_err", 64'({b_err0, b_escMem}), 64'd0);

    // Random single transactions.
    for (int k = 0; k < 40; k++) begin
      int          c = int'($urandom_range(0, 1));
      logic        w = 1'($urandom_range(0, 1));
      logic [31:0] a = ($urandom_range(0, 7) == 0) ? 32'd512 + $urandom_range(0, 1000)
                                                   : 32'($urandom_range(0, 15));
      txn(c, w, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
